cam_frame_writer: RTL and testbench
===================================

Name: cam_frame_writer

Overview:
- Parametrised successor to the fixed-size camera capture path: packs OV-series byte-stream pixels (RGB565, two bytes per pixel) into PIX_W-bit words and generates linear frame-buffer write addresses/strobes for the dual-port frame RAM.
- Adds what the fixed path lacks: configurable resolution, RGB565 or RGB444 output, a settle-frame skip after reset, frame freeze (capture_en), frame-done pulse/counter, and line-length error flagging with address clamping.
- Sits between the camera pins (synchronised into clk) and RAM port A.

Parameters:
- H_ACTIVE, 640, pixels per line written
- V_ACTIVE, 480, lines per frame written
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- PIX_W, 12, output pixel width; 12 = RGB444 (top 4 bits of each channel), 16 = RGB565 passthrough
- SKIP_FRAMES, 10, complete frames discarded after reset before the first write

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cam_vsync  in  1  frame sync, high during vertical blanking
- cam_href  in  1  line valid, high while bytes are valid
- cam_data  in  8  camera byte, sampled when cam_href=1
- capture_en  in  1  1 = write frames; 0 = freeze buffer after current frame
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  PIX_W  packed pixel
- frame_done  out  1  one-cycle pulse after the last pixel of a written frame
- frame_cnt  out  8  count of written frames, wraps 255->0
- line_err  out  1  sticky: any line whose pixel count differs from H_ACTIVE; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state SETTLE; skip counter, byte phase, x, y cleared.
- Inputs used directly on clk; vsync edge detected via one register (vs_d). Frame start = falling edge of cam_vsync.
- States:
  - SETTLE: count vsync falling edges. After SKIP_FRAMES edges -> WAIT_VS. SKIP_FRAMES=0 skips straight to WAIT_VS.
  - WAIT_VS: on vsync falling edge, if capture_en=1 -> CAPTURE (x=0, y=0, phase=0); else stay.
  - CAPTURE: pack bytes. A vsync rising edge -> DONE.
  - DONE: issue frame_done for 1 cycle, increment frame_cnt -> WAIT_VS.
- Byte packing: phase toggles on each clk with cam_href=1.
  - phase 0: latch hi byte.
  - phase 1: form p565 = {hi, cam_data}.
- Write output: registered, 1-cycle latency after the second byte. wr_en=1 for exactly one cycle per pixel. wr_addr = y*H_ACTIVE + x, kept as an incrementing running address, no multiplier. wr_data = p565 (PIX_W=16), or {p565[15:12], p565[10:7], p565[4:1]} (PIX_W=12).
- Line end (cam_href falling edge):
  - phase reset to 0; a dangling odd byte is discarded.
  - If x != H_ACTIVE, set line_err.
  - If y < V_ACTIVE, increment y and set x=0.
- Clamping: pixels with x >= H_ACTIVE or y >= V_ACTIVE are dropped (no wr_en) and set line_err. Address never exceeds H_ACTIVE*V_ACTIVE-1.
- Short frame (vsync rises with y < V_ACTIVE): still -> DONE; frame_done still pulses.
- capture_en sampled only in WAIT_VS. Deasserting mid-frame completes the current frame.
- vsync falling edge while in CAPTURE (glitch/missed rise): treat as new frame start; restart at address 0 with no frame_done.
- Reset mid-frame: immediate return to SETTLE; no further writes.

Decomposition:
- Shared package cam_pkg: state enum (SETTLE, WAIT_VS, CAPTURE, DONE), RGB565->RGB444 slice constants, H_ACTIVE/V_ACTIVE defaults shared with the VGA reader.
- One natural sub-module: cam_byte_packer (phase toggle, hi-byte latch, 565/444 formatting, 1-cycle output register). FSM and addressing stay in the top.

Test Plan:
- SKIP_FRAMES=2, H=4, V=2, capture_en=1: first two frames -> no wr_en; third frame -> 8 writes at addr 0..7, frame_done once, frame_cnt=1.
- PIX_W=12, byte pair 0xF8,0x1F -> wr_data=0xF0F one cycle after second byte. PIX_W=16, same pair -> 0xF81F.
- Line with 9 bytes (H=4) -> 4 writes, odd byte dropped, line_err=1, next line starts at addr 4.
- Line with 6 pixels (H=4) -> only addr 0..3 written for that line, line_err=1, no address overrun.
- capture_en dropped mid-frame 3 -> frame 3 completes; frames 4+ have no wr_en, frame_cnt frozen; re-raise -> capture resumes at the next vsync falling edge.
- rst_n pulsed low mid-CAPTURE -> wr_en, frame_cnt, line_err = 0 asynchronously; SETTLE frames skipped again before the next write.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Brief    : Shared definitions for the camera capture path: FSM state
//            encoding, RGB565 -> RGB444 slice positions and default frame
//            geometry shared with the VGA reader.
// Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

    // Default frame geometry, also used by the VGA read side
    localparam int c_H_ACTIVE_DEF = 640;
    localparam int c_V_ACTIVE_DEF = 480;

    // Capture FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_SETTLE  = 2'd0;
    localparam state_t c_ST_WAIT_VS = 2'd1;
    localparam state_t c_ST_CAPTURE = 2'd2;
    localparam state_t c_ST_DONE    = 2'd3;

    // Top four bits of each RGB565 channel form the RGB444 pixel
    localparam int c_R_MSB = 15;
    localparam int c_R_LSB = 12;
    localparam int c_G_MSB = 10;
    localparam int c_G_LSB = 7;
    localparam int c_B_MSB = 4;
    localparam int c_B_LSB = 1;

endpackage
`default_nettype wire

// File: rtl/cam_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : cam_byte_packer
// Brief    : Pairs camera bytes into RGB565 pixels, formats them to PIX_W
//            bits and holds the formatted pixel in an output register.
// Revision : 1.0 - initial release
// ============================================================================
module cam_byte_packer
    import cam_pkg::*;
#(
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_href,
    input  logic [7:0]       i_data,
    output logic             o_phase,
    output logic             o_pix_stb,
    output logic [PIX_W-1:0] o_pix_data
);

    logic             r_phase;
    logic [7:0]       r_hi;
    logic [PIX_W-1:0] r_pix_data;
    logic [15:0]      w_p565;
    logic [PIX_W-1:0] w_fmt;

    assign w_p565    = {r_hi, i_data};
    assign o_pix_stb = i_href & r_phase & ~i_clear;
    assign o_phase   = r_phase;
    assign o_pix_data = r_pix_data;

    // Byte phase: toggles per valid byte, falls back to 0 whenever href drops
    // so a dangling odd byte never pairs with the next line's first byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
        end else if (i_clear || !i_href) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    // High byte latch on the first byte of each pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 8'd0;
        end else if (i_href && !r_phase) begin
            r_hi <= i_data;
        end
    end

    generate
        if (PIX_W == 12) begin : g_rgb444
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^{w_p565[11], w_p565[6:5], w_p565[0]};
            assign w_fmt = {w_p565[c_R_MSB:c_R_LSB],
                            w_p565[c_G_MSB:c_G_LSB],
                            w_p565[c_B_MSB:c_B_LSB]};
        end else begin : g_rgb565
            assign w_fmt = PIX_W'(w_p565);
        end
    endgenerate

    // Output register: formatted pixel appears one cycle after the second byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_data <= '0;
        end else if (o_pix_stb) begin
            r_pix_data <= w_fmt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cam_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : cam_frame_writer
// Brief    : Camera byte stream to frame-RAM writer with settle-frame skip,
//            capture freeze, frame-done pulse/counter and line-length error
//            flagging with address clamping.
// Revision : 1.0 - initial release
// ============================================================================
module cam_frame_writer #(
    parameter int H_ACTIVE    = cam_pkg::c_H_ACTIVE_DEF,
    parameter int V_ACTIVE    = cam_pkg::c_V_ACTIVE_DEF,
    parameter int ADDR_W      = 19,
    parameter int PIX_W       = 12,
    parameter int SKIP_FRAMES = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err
);

    import cam_pkg::*;

    localparam int c_X_W    = $clog2(H_ACTIVE + 1);
    localparam int c_Y_W    = $clog2(V_ACTIVE + 1);
    localparam int c_SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [c_X_W-1:0]    c_X_END     = c_X_W'(H_ACTIVE);
    localparam logic [c_Y_W-1:0]    c_Y_END     = c_Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0]   c_LINE_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [c_SKIP_W-1:0] c_SKIP_LAST =
        c_SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_vs_d;
    logic                r_href_d;
    logic [c_SKIP_W-1:0] r_skip_cnt;
    logic [c_X_W-1:0]    r_x;
    logic [c_Y_W-1:0]    r_y;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_line_base;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_wr_en;
    logic                r_frame_done;
    logic [7:0]          r_frame_cnt;
    logic                r_line_err;

    logic w_vs_fall;
    logic w_vs_rise;
    logic w_href_fall;
    logic w_frame_start;
    logic w_in_bounds;
    logic w_pix_stb;
    logic w_phase;

    assign w_vs_fall   =  r_vs_d & ~cam_vsync;
    assign w_vs_rise   = ~r_vs_d &  cam_vsync;
    assign w_href_fall =  r_href_d & ~cam_href;
    // A falling vsync while capturing means a missed rise: restart the frame
    assign w_frame_start = w_vs_fall &&
                           (((r_state == c_ST_WAIT_VS) && capture_en) ||
                            (r_state == c_ST_CAPTURE));
    assign w_in_bounds = (r_x < c_X_END) && (r_y < c_Y_END);

    cam_byte_packer #(
        .PIX_W (PIX_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_frame_start),
        .i_href     (cam_href),
        .i_data     (cam_data),
        .o_phase    (w_phase),
        .o_pix_stb  (w_pix_stb),
        .o_pix_data (wr_data)
    );

    // Previous-cycle copies of vsync/href for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d   <= 1'b0;
            r_href_d <= 1'b0;
        end else begin
            r_vs_d   <= cam_vsync;
            r_href_d <= cam_href;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_SETTLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_SETTLE: begin
                if (SKIP_FRAMES == 0) begin
                    w_state_nxt = c_ST_WAIT_VS;
                end else if (w_vs_fall && (r_skip_cnt == c_SKIP_LAST)) begin
                    w_state_nxt = c_ST_WAIT_VS;
                end
            end
            c_ST_WAIT_VS: begin
                if (w_vs_fall && capture_en) begin
                    w_state_nxt = c_ST_CAPTURE;
                end
            end
            c_ST_CAPTURE: begin
                if (w_vs_rise) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_WAIT_VS;
            end
            default: begin
                w_state_nxt = c_ST_SETTLE;
            end
        endcase
    end

    // Settle-frame counter: counts frame starts seen while settling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= '0;
        end else if ((r_state == c_ST_SETTLE) && w_vs_fall) begin
            r_skip_cnt <= r_skip_cnt + 1'b1;
        end
    end

    // Pixel addressing, clamped writes, line checks and frame accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_line_base  <= '0;
            r_wr_addr    <= '0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_line_err   <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_frame_start) begin
                r_x         <= '0;
                r_y         <= '0;
                r_addr      <= '0;
                r_line_base <= '0;
            end else if (r_state == c_ST_CAPTURE) begin
                if (w_pix_stb) begin
                    if (w_in_bounds) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_addr    <= r_addr + 1'b1;
                        r_x       <= r_x + 1'b1;
                    end else begin
                        r_line_err <= 1'b1;
                    end
                end
                if (w_href_fall) begin
                    // Short line, or an odd byte left over, is a length error
                    if ((r_x != c_X_END) || w_phase) begin
                        r_line_err <= 1'b1;
                    end
                    // Jump to the next line's base so short lines don't shift the image
                    if (r_y < c_Y_END) begin
                        r_y         <= r_y + 1'b1;
                        r_x         <= '0;
                        r_line_base <= r_line_base + c_LINE_STEP;
                        r_addr      <= r_line_base + c_LINE_STEP;
                    end
                end
            end
            if (r_state == c_ST_DONE) begin
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign line_err   = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_frame_writer
// Brief    : Directed self-checking bench for cam_frame_writer (4x2 frame,
//            two settle frames, RGB444 and RGB565 instances side by side).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_frame_writer;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       cam_vsync  = 1'b1;
    logic       cam_href   = 1'b0;
    logic [7:0] cam_data   = 8'd0;
    logic       capture_en = 1'b1;

    logic        wr_en12,  wr_en16;
    logic [3:0]  wr_addr12, wr_addr16;
    logic [11:0] wr_data12;
    logic [15:0] wr_data16;
    logic        frame_done12, frame_done16;
    logic [7:0]  frame_cnt12, frame_cnt16;
    logic        line_err12, line_err16;

    int n_cmp  = 0;
    int n_fail = 0;

    // write log filled by the monitor
    int          nw    = 0;
    int          ndone = 0;
    logic [3:0]  log_a   [0:31];
    logic [11:0] log_d12 [0:31];
    logic [15:0] log_d16 [0:31];

    logic [7:0] lb0 [0:11] = '{8'hF8, 8'h1F, 8'h12, 8'h34, 8'h00, 8'h00,
                               8'hFF, 8'hFF, 8'h5A, 8'h11, 8'h22, 8'h33};
    logic [7:0] lb1 [0:11] = '{8'h80, 8'h00, 8'h04, 8'h00, 8'h00, 8'h10,
                               8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [11:0] e12 [0:7] = '{12'hF0F, 12'h14A, 12'h000, 12'hFFF,
                               12'h800, 12'h080, 12'h008, 12'hA76};
    logic [15:0] e16 [0:7] = '{16'hF81F, 16'h1234, 16'h0000, 16'hFFFF,
                               16'h8000, 16'h0400, 16'h0010, 16'hABCD};

    cam_frame_writer #(
        .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(4), .PIX_W(12), .SKIP_FRAMES(2)
    ) dut12 (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .wr_en(wr_en12),
        .wr_addr(wr_addr12), .wr_data(wr_data12), .frame_done(frame_done12),
        .frame_cnt(frame_cnt12), .line_err(line_err12)
    );

    cam_frame_writer #(
        .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(4), .PIX_W(16), .SKIP_FRAMES(2)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .wr_en(wr_en16),
        .wr_addr(wr_addr16), .wr_data(wr_data16), .frame_done(frame_done16),
        .frame_cnt(frame_cnt16), .line_err(line_err16)
    );

    always #5 clk = ~clk;

    // record every write and frame_done pulse, sampled on the falling edge
    always @(negedge clk) begin
        if (wr_en12) begin
            if (nw < 32) begin
                log_a[nw]   = wr_addr12;
                log_d12[nw] = wr_data12;
                log_d16[nw] = wr_data16;
            end
            nw = nw + 1;
        end
        if (frame_done12) ndone = ndone + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_line(input int sel, input int n, input bit chk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk && i == 1) begin
                n_cmp++;
                if (wr_en12 !== 1'b0) begin n_fail++; $display("FAIL early_wr_en: got %b want 0", wr_en12); end
            end
            if (chk && i == 2) begin
                n_cmp++;
                if (wr_en12 !== 1'b1) begin n_fail++; $display("FAIL lat_wr_en: got %b want 1", wr_en12); end
                n_cmp++;
                if (wr_data12 !== 12'hF0F) begin n_fail++; $display("FAIL lat_data444: got %h want f0f", wr_data12); end
                n_cmp++;
                if (wr_data16 !== 16'hF81F) begin n_fail++; $display("FAIL lat_data565: got %h want f81f", wr_data16); end
                n_cmp++;
                if (wr_addr12 !== 4'd0) begin n_fail++; $display("FAIL lat_addr: got %0d want 0", wr_addr12); end
            end
            cam_href = 1'b1;
            cam_data = (sel == 0) ? lb0[i] : lb1[i];
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'd0;
        cyc(2);
    endtask

    task automatic run_frame(input int n0, input int n1, input bit chk, input bit drop);
        cyc(2);
        cam_vsync = 1'b0;
        cyc(2);
        send_line(0, n0, chk);
        if (drop) capture_en = 1'b0;
        send_line(1, n1, 1'b0);
        cyc(1);
        cam_vsync = 1'b1;
        cyc(6);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        cyc(2);
        n_cmp++; if (wr_en12 !== 1'b0)      begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en12); end
        n_cmp++; if (wr_addr12 !== 4'd0)    begin n_fail++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr12); end
        n_cmp++; if (wr_data12 !== 12'd0)   begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", wr_data12); end
        n_cmp++; if (frame_done12 !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", frame_done12); end
        n_cmp++; if (frame_cnt12 !== 8'd0)  begin n_fail++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt12); end
        n_cmp++; if (line_err12 !== 1'b0)   begin n_fail++; $display("FAIL rst_line_err: got %b want 0", line_err12); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_settle_and_frame();
        nw = 0; ndone = 0;
        run_frame(8, 8, 1'b0, 1'b0);
        run_frame(8, 8, 1'b0, 1'b0);
        n_cmp++; if (nw !== 0)    begin n_fail++; $display("FAIL settle_writes: got %0d want 0", nw); end
        n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL settle_done: got %0d want 0", ndone); end
        nw = 0;
        run_frame(8, 8, 1'b1, 1'b0);
        n_cmp++; if (nw !== 8) begin n_fail++; $display("FAIL frame_writes: got %0d want 8", nw); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (log_a[i] !== 4'(i)) begin n_fail++; $display("FAIL frame_addr[%0d]: got %0d want %0d", i, log_a[i], i); end
            n_cmp++; if (log_d12[i] !== e12[i]) begin n_fail++; $display("FAIL frame_d444[%0d]: got %h want %h", i, log_d12[i], e12[i]); end
            n_cmp++; if (log_d16[i] !== e16[i]) begin n_fail++; $display("FAIL frame_d565[%0d]: got %h want %h", i, log_d16[i], e16[i]); end
        end
        n_cmp++; if (ndone !== 1)          begin n_fail++; $display("FAIL frame_done_cnt: got %0d want 1", ndone); end
        n_cmp++; if (frame_cnt12 !== 8'd1) begin n_fail++; $display("FAIL frame_cnt: got %0d want 1", frame_cnt12); end
        n_cmp++; if (line_err12 !== 1'b0)  begin n_fail++; $display("FAIL frame_line_err: got %b want 0", line_err12); end
    endtask

    task automatic test_odd_byte();
        nw = 0;
        run_frame(9, 8, 1'b0, 1'b0);
        n_cmp++; if (nw !== 8) begin n_fail++; $display("FAIL odd_writes: got %0d want 8", nw); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (log_a[i] !== 4'(i)) begin n_fail++; $display("FAIL odd_addr[%0d]: got %0d want %0d", i, log_a[i], i); end
        end
        n_cmp++; if (log_d12[4] !== 12'h800) begin n_fail++; $display("FAIL odd_next_line_data: got %h want 800", log_d12[4]); end
        n_cmp++; if (line_err12 !== 1'b1)    begin n_fail++; $display("FAIL odd_line_err: got %b want 1", line_err12); end
        n_cmp++; if (frame_cnt12 !== 8'd2)   begin n_fail++; $display("FAIL odd_frame_cnt: got %0d want 2", frame_cnt12); end
    endtask

    task automatic test_overrun();
        do_reset();
        n_cmp++; if (line_err12 !== 1'b0)  begin n_fail++; $display("FAIL ovr_pre_line_err: got %b want 0", line_err12); end
        n_cmp++; if (frame_cnt12 !== 8'd0) begin n_fail++; $display("FAIL ovr_pre_frame_cnt: got %0d want 0", frame_cnt12); end
        run_frame(8, 8, 1'b0, 1'b0);
        run_frame(8, 8, 1'b0, 1'b0);
        nw = 0;
        run_frame(12, 8, 1'b0, 1'b0);
        n_cmp++; if (nw !== 8) begin n_fail++; $display("FAIL ovr_writes: got %0d want 8", nw); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (log_a[i] !== 4'(i)) begin n_fail++; $display("FAIL ovr_addr[%0d]: got %0d want %0d", i, log_a[i], i); end
        end
        n_cmp++; if (log_d12[3] !== 12'hFFF) begin n_fail++; $display("FAIL ovr_last_pix: got %h want fff", log_d12[3]); end
        n_cmp++; if (log_d12[4] !== 12'h800) begin n_fail++; $display("FAIL ovr_next_line: got %h want 800", log_d12[4]); end
        n_cmp++; if (line_err12 !== 1'b1)    begin n_fail++; $display("FAIL ovr_line_err: got %b want 1", line_err12); end
    endtask

    task automatic test_capture_en();
        nw = 0; ndone = 0;
        run_frame(8, 8, 1'b0, 1'b1);
        n_cmp++; if (nw !== 8)             begin n_fail++; $display("FAIL cen_finish_writes: got %0d want 8", nw); end
        n_cmp++; if (ndone !== 1)          begin n_fail++; $display("FAIL cen_finish_done: got %0d want 1", ndone); end
        n_cmp++; if (frame_cnt12 !== 8'd2) begin n_fail++; $display("FAIL cen_finish_cnt: got %0d want 2", frame_cnt12); end
        nw = 0;
        run_frame(8, 8, 1'b0, 1'b0);
        n_cmp++; if (nw !== 0)             begin n_fail++; $display("FAIL cen_frozen_writes: got %0d want 0", nw); end
        n_cmp++; if (ndone !== 1)          begin n_fail++; $display("FAIL cen_frozen_done: got %0d want 1", ndone); end
        n_cmp++; if (frame_cnt12 !== 8'd2) begin n_fail++; $display("FAIL cen_frozen_cnt: got %0d want 2", frame_cnt12); end
        capture_en = 1'b1;
        nw = 0;
        run_frame(8, 8, 1'b0, 1'b0);
        n_cmp++; if (nw !== 8)             begin n_fail++; $display("FAIL cen_resume_writes: got %0d want 8", nw); end
        n_cmp++; if (frame_cnt12 !== 8'd3) begin n_fail++; $display("FAIL cen_resume_cnt: got %0d want 3", frame_cnt12); end
    endtask

    task automatic test_reset_mid_frame();
        cyc(2);
        cam_vsync = 1'b0;
        cyc(2);
        send_line(0, 8, 1'b0);
        @(negedge clk); cam_href = 1'b1; cam_data = lb1[0];
        @(negedge clk); cam_data = lb1[1];
        @(negedge clk);
        n_cmp++; if (wr_en12 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wr_en: got %b want 1", wr_en12); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (wr_en12 !== 1'b0)     begin n_fail++; $display("FAIL mid_async_wr_en: got %b want 0", wr_en12); end
        n_cmp++; if (frame_cnt12 !== 8'd0) begin n_fail++; $display("FAIL mid_async_cnt: got %0d want 0", frame_cnt12); end
        n_cmp++; if (line_err12 !== 1'b0)  begin n_fail++; $display("FAIL mid_async_line_err: got %b want 0", line_err12); end
        cam_href = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        cam_vsync = 1'b1;
        cyc(6);
        nw = 0;
        run_frame(8, 8, 1'b0, 1'b0);
        run_frame(8, 8, 1'b0, 1'b0);
        n_cmp++; if (nw !== 0) begin n_fail++; $display("FAIL mid_resettle_writes: got %0d want 0", nw); end
        run_frame(8, 8, 1'b0, 1'b0);
        n_cmp++; if (nw !== 8)             begin n_fail++; $display("FAIL mid_recap_writes: got %0d want 8", nw); end
        n_cmp++; if (log_a[7] !== 4'd7)    begin n_fail++; $display("FAIL mid_recap_last_addr: got %0d want 7", log_a[7]); end
        n_cmp++; if (frame_cnt12 !== 8'd1) begin n_fail++; $display("FAIL mid_recap_cnt: got %0d want 1", frame_cnt12); end
    endtask

    initial begin
        test_reset();
        test_settle_and_frame();
        test_odd_byte();
        test_overrun();
        test_capture_en();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
